// File: rtl/accum_decoder_pkg.sv
// Shared defaults and FSM encoding for the accumulator-sum decoder.
// Imported by the difference stage and the top level.
package accum_decoder_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int N_ITER_DEF = 100;
  localparam int CNT_W_DEF  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/accum_decoder_diff.sv
// Registered subtract/compare stage: recovers |x(n)| = y(n) - y(n-1) and
// reports whether the incoming sum is below the previous one.
module accum_decoder_diff
  import accum_decoder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] x_mag,
  output logic              x_valid,
  output logic              decr
);

  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] x_mag_q, x_mag_d;
  logic              x_valid_q, x_valid_d;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    prev_d    = prev_q;
    x_mag_d   = x_mag_q;
    x_valid_d = 1'b0;
    if (clear) begin
      prev_d = '0;
    end else if (accept) begin
      x_mag_d   = y - prev_q;
      x_valid_d = 1'b1;
      prev_d    = y;
    end
  end

  // NOTE: flops are updated with <= so every always_ff reads pre-edge values;
  // a blocking = here would make results depend on block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q    <= '0;
      x_mag_q   <= '0;
      x_valid_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      x_mag_q   <= x_mag_d;
      x_valid_q <= x_valid_d;
    end
  end

  // Combinational so the top can set err on the same edge that registers x_mag.
  assign decr    = accept && (y < prev_q);
  assign x_mag   = x_mag_q;
  assign x_valid = x_valid_q;

endmodule

// File: rtl/accum_decoder.sv
// Decoder for the running-sum accumulator: FSM, sample counter, sticky
// done/err flags around the registered difference stage.
module accum_decoder
  import accum_decoder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_ITER = N_ITER_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] x_mag,
  output logic              x_valid,
  output logic [CNT_W-1:0]  cnt,
  output logic              done,
  output logic              err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic accept;
  logic clear;
  logic decr;

  assign accept = (state_q == ST_RUN) && en;
  // start is only honoured outside RUN; inside RUN it is ignored.
  assign clear  = start && (state_q != ST_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (en) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (decr) err_d = 1'b1;
          if (cnt_q == CNT_W'(N_ITER - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  accum_decoder_diff #(
    .DATA_W (DATA_W)
  ) u_diff (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .accept  (accept),
    .y       (y),
    .x_mag   (x_mag),
    .x_valid (x_valid),
    .decr    (decr)
  );

  assign cnt  = cnt_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_accum_decoder.sv
// Self-checking bench for accum_decoder: directed runs plus random sums,
// compared against a sample-history model of the decoder.
module tb_accum_decoder;
  import accum_decoder_pkg::*;

  localparam int DW = 32;
  localparam int N  = 100;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          en;
  logic [DW-1:0] y;
  logic [DW-1:0] x_mag;
  logic          x_valid;
  logic [CW-1:0] cnt;
  logic          done;
  logic          err;

  accum_decoder #(
    .DATA_W (DW),
    .N_ITER (N),
    .CNT_W  (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .en      (en),
    .y       (y),
    .x_mag   (x_mag),
    .x_valid (x_valid),
    .cnt     (cnt),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: the list of sums accepted in the current run, plus the last output.
  logic [DW-1:0] samples[$];
  bit            run_active = 1'b0;
  logic [DW-1:0] m_xmag     = '0;
  bit            m_xvalid   = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h (cnt_model=%0d)", tag, obs, exp, samples.size());
    end
  endtask

  function automatic bit any_decrease();
    for (int i = 1; i < samples.size(); i++)
      if (samples[i] < samples[i-1]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input bit r, input bit s, input bit e, input logic [DW-1:0] yv);
    logic [DW-1:0] prevv;
    rst   = r;
    start = s;
    en    = e;
    y     = yv;
    @(posedge clk);
    #1;
    if (!r) begin
      samples.delete();
      run_active = 1'b0;
      m_xmag     = '0;
      m_xvalid   = 1'b0;
    end else if (!run_active) begin
      m_xvalid = 1'b0;
      if (s) begin
        samples.delete();
        run_active = 1'b1;
      end
    end else if (e) begin
      prevv = (samples.size() > 0) ? samples[$] : '0;
      samples.push_back(yv);
      m_xmag   = yv - prevv;
      m_xvalid = 1'b1;
      if (samples.size() == N) run_active = 1'b0;
    end else begin
      m_xvalid = 1'b0;
    end
    check("x_valid", DW'(x_valid), DW'(m_xvalid));
    check("x_mag",   x_mag,        m_xmag);
    check("cnt",     DW'(cnt),     DW'(samples.size()));
    check("done",    DW'(done),    DW'(samples.size() == N));
    check("err",     DW'(err),     DW'(any_decrease()));
  endtask

  // mode 0: y=3,6,9..  1: 10,20,15,25,25..  2: random non-decreasing
  // mode 3: wrap boundary then random growth  4: fully random sums
  task automatic run(input int mode, input int gap_at, input int abort_at, input int start_at);
    int            guard = 0;
    int            gap   = 0;
    bit            started_mid = 1'b0;
    int            n;
    logic [DW-1:0] last;
    logic [DW-1:0] yv;
    logic [DW-1:0] tbl[4] = '{32'd10, 32'd20, 32'd15, 32'd25};
    step(1'b1, 1'b1, 1'b0, '0);
    while (run_active && guard < 1000) begin
      guard++;
      n    = samples.size();
      last = (n > 0) ? samples[$] : '0;
      case (mode)
        0:       yv = DW'(3 * (n + 1));
        1:       yv = (n < 4) ? tbl[n] : 32'd25;
        2:       yv = last + DW'($urandom_range(0, 5000));
        3:       yv = (n == 0) ? 32'hFFFF_FFF0 : (n == 1) ? 32'h0000_0010
                                : last + DW'($urandom_range(0, 5000));
        default: yv = $urandom();
      endcase
      if (n == abort_at) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b1, yv);
      end else if (n == gap_at && gap < 5) begin
        step(1'b1, 1'b0, 1'b0, $urandom());
        gap++;
        check("gap_cnt_hold", DW'(cnt), DW'(gap_at));
      end else if (n == start_at && !started_mid) begin
        step(1'b1, 1'b1, 1'b1, yv);
        started_mid = 1'b1;
      end else begin
        step(1'b1, 1'b0, (mode < 2) || ($urandom_range(0, 3) != 0), yv);
      end
      if (mode == 1 && samples.size() == 3) begin
        check("dec_xmag", x_mag, 32'hFFFF_FFFB);
        check("dec_err",  DW'(err), 32'd1);
      end
      if (mode == 3 && samples.size() == 1 && x_valid) check("wrap_xmag0", x_mag, 32'hFFFF_FFF0);
      if (mode == 3 && samples.size() == 2 && x_valid) begin
        check("wrap_xmag1", x_mag, 32'h0000_0020);
        check("wrap_err",   DW'(err), 32'd1);
      end
    end
    if (guard >= 1000) begin
      n_assert++;
      n_fail++;
      $display("FAIL run_guard: observed=no_completion expected=completion mode=%0d", mode);
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    en    = 1'b0;
    y     = '0;

    repeat (3) step(1'b0, 1'b0, 1'b0, '0);
    repeat (3) step(1'b1, 1'b0, 1'b1, $urandom());

    run(0, -1, -1, -1);
    check("run0_cnt",  DW'(cnt),  DW'(N));
    check("run0_done", DW'(done), 32'd1);
    check("run0_err",  DW'(err),  32'd0);
    check("run0_xmag", x_mag,     32'd3);
    repeat (3) step(1'b1, 1'b0, 1'b1, $urandom());

    run(0, 10, -1, -1);
    run(1, -1, -1, -1);
    check("dec_err_done", DW'(err), 32'd1);

    run(2, -1, 50, -1);
    check("abort_cnt",  DW'(cnt),  32'd0);
    check("abort_xv",   DW'(x_valid), 32'd0);
    repeat (4) step(1'b1, 1'b0, 1'b1, $urandom());

    run(2, -1, -1, 30);
    check("startmid_done", DW'(done), 32'd1);
    run(3, -1, -1, -1);
    run(4, -1, -1, -1);
    run(2, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_decoder.md
Name: accum_decoder

Overview:
- Receive-side counterpart of the 100-iteration magnitude accumulator.
- Consumes the accumulator's running sum y(n) and recovers each sample magnitude |x(n)| = y(n) − y(n−1).
- Counts accepted samples, signals completion after N_ITER samples, and flags sequences that are not monotonically non-decreasing.
- Sits downstream of the accumulator output, e.g. as a checker or stream reconstructor.

Parameters:
- DATA_W, 32, width of the accumulated sum and of the recovered magnitude
- N_ITER, 100, number of samples per run
- CNT_W, 7, sample-counter width; must satisfy 2^CNT_W ≥ N_ITER

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-low reset
- start  input  1  single-cycle pulse; arms a new run
- en  input  1  y is valid this cycle
- y  input  DATA_W  running accumulated sum, unsigned
- x_mag  output  DATA_W  recovered magnitude, registered
- x_valid  output  1  x_mag valid; one-cycle pulse per accepted sample
- cnt  output  CNT_W  samples accepted in the current run
- done  output  1  run complete; level
- err  output  1  sticky: a sum decreased during the run

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE
  - x_mag=0, x_valid=0, cnt=0, done=0, err=0
  - internal prev=0
  - Reset overrides every other input in the same cycle, including mid-run.
- States: IDLE, RUN, DONE.
- IDLE:
  - en ignored, x_valid=0.
  - start=1 → RUN; prev<=0, cnt<=0, err<=0, done<=0.
- RUN, en=1:
  - x_mag<=y−prev, modulo 2^DATA_W (wrap, no saturation).
  - x_valid<=1, prev<=y, cnt<=cnt+1.
  - If y<prev (unsigned): err<=1. x_mag still carries the wrapped difference.
  - Latency: one cycle from en/y to x_valid/x_mag.
- RUN, en=0: x_valid<=0; prev, cnt and err hold.
- RUN exit: when the accepted sample brings cnt to N_ITER, state<=DONE and done<=1 in the same edge as the final x_valid.
- RUN, start=1: ignored, whether or not en=1 in the same cycle.
- DONE:
  - done held at 1; cnt holds N_ITER; err holds.
  - en ignored, x_valid=0.
  - start=1 → RUN with the same initialisation as from IDLE; done<=0 on that edge.
- x_mag holds its last value whenever x_valid=0.
- cnt never wraps; the RUN→DONE transition occurs at cnt=N_ITER.
- First sample of a run: prev=0, so x_mag=y(0).

Decomposition:
- Shared package: N_ITER, DATA_W, CNT_W defaults; state encoding constants ST_IDLE=0, ST_RUN=1, ST_DONE=2 (2-bit).
- One natural sub-module, accum_decoder_diff:
  - Registered subtract and unsigned compare stage.
  - Holds prev; produces x_mag, x_valid and a decrease flag.
  - Enabled by the top FSM.
- Top level keeps the FSM, counter and sticky err/done.

Test Plan:
- Reset release, start pulse, 100 cycles en=1 with y=3,6,9,…,300 → x_mag=3 every sample; x_valid high 100 cycles; cnt reaches 100; done=1 on the edge of the final x_valid; err=0.
- Same run with en deasserted on cycles 10–14 → x_valid=0 during the gap; x_mag holds; cnt holds at 10; total 100 pulses; done only after sample 100.
- y sequence 10,20,15,25 (then constant 25) → x_mag=10,10,0xFFFFFFFB,10,0…; err=1 from sample 3 and held through DONE.
- rst=0 asserted at cnt=50 mid-run → next cycle all outputs 0, state IDLE; en ignored until start; new run begins with prev=0.
- start pulsed at cnt=30 in RUN → ignored, run completes at 100. start in DONE → done=0, cnt=0, new run begins.
- Wrap boundary: y(0)=0xFFFFFFF0, y(1)=0x00000010 → x_mag=0xFFFFFFF0 then 0x00000020, err=1.
